uart_tx: RTL
============

# uart_tx

Serial transmitter for the UART path. It takes bytes from the core logic through a valid/ready handshake and drives them onto the TX line as 8N1 frames: one start bit, eight data bits LSB first, one stop bit, line idle high. It sits directly upstream of the UART receiver and drives the serial line that the receiver samples. Its baud rate comes from a parameterised divider, so a single bench can loop TX back into the receiver.

## Interface
Parameters:
- BAUD_DIV, default 5208: CLK cycles per bit (50 MHz / 9600 baud). Legal range 2..65535.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- DATA_T  in  8  byte to transmit; sampled only on the accept edge.
- VALID  in  1  DATA_T holds a byte to send.
- READY  out  1  transmitter can accept a byte; combinational, equal to (state == IDLE).
- TX  out  1  serial line, registered; idles high.
- BUSY  out  1  a frame is in progress; equal to (state != IDLE).

## Operation
- States:
  - IDLE: TX = 1, READY = 1.
  - START: TX = 0.
  - DATA: TX = shift[0]; bit index runs 0..7.
  - STOP: TX = 1.
- Accept: on an edge where VALID = 1 and READY = 1, the block performs all of the following:
  - latches DATA_T into an 8-bit shift register;
  - clears the baud counter and the bit index;
  - moves to START;
  - registers TX to 0.
- The baud counter counts 0..BAUD_DIV-1. A "tick" is the cycle where the counter equals BAUD_DIV-1; on the tick the counter wraps to 0.
- State moves on each tick:
  - START → DATA, TX = bit 0.
  - DATA with index < 7: shift right, index +1, TX = next bit.
  - DATA with index = 7: → STOP, TX = 1.
  - STOP → IDLE.
- VALID while BUSY = 1 is ignored. DATA_T changes after the accept edge have no effect on the frame in progress.
- VALID is never required to stay high. The handshake is a pure valid/ready transfer: no byte is lost or duplicated.
- Reset (RST_N low, at any time, including mid-frame):
  - the frame is aborted immediately, with no clock edge needed;
  - TX = 1, state = IDLE, READY = 1, BUSY = 0;
  - counter, index and shift register = 0.
- After reset is released, the first VALID is accepted on the first rising edge.

## Timing
- Accept edge k: TX = 0 from edge k through edge k+BAUD_DIV.
- Each bit is held for exactly BAUD_DIV cycles. The frame occupies 10·BAUD_DIV cycles on the line.
- The last STOP tick returns the block to IDLE. READY is high in the following cycle.
- Back-to-back transfers with VALID held high: consecutive accept edges are 10·BAUD_DIV + 1 cycles apart. This leaves one extra idle-high cycle between frames, which the receiver tolerates.
- Latency from the accept edge to the start-bit falling edge on TX: 1 edge (TX changes at the accept edge itself).
- BAUD_DIV = 2 is the minimum. There is no special case for BAUD_DIV = 1, which is illegal; the bench checks it with an elaboration-time assertion.

## Structure
- Shared package uart_pkg, also used by the receiver, holds:
  - the state encoding: IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  - DATA_BITS = 8;
  - the default BAUD_DIV = 5208;
  - the baud-counter width = 16.
- One sub-module: uart_baud_gen.
  - Contains the 16-bit counter.
  - Inputs: CLK, RST_N, clr (driven on accept), en (= BUSY).
  - Output: tick.
  - The receiver is to reuse it in place of its ad-hoc divider.
- Top level: the FSM, the shift register, the 3-bit bit index and the TX register.

## Test plan
All scenarios use BAUD_DIV = 4.
- Reset values: hold RST_N low 3 cycles, then release. TX = 1, READY = 1, BUSY = 0 throughout reset and after release.
- Single byte: send 0xA5. TX reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. BUSY is high for 40 cycles. READY rises on cycle 41 after the accept edge.
- Back-to-back: send 0x00 then 0xFF with VALID held high. The second accept is 41 cycles after the first. The line reads start + 8×0 + stop, one idle cycle, start + 8×1 + stop.
- Ignore while busy: during the 0x3C frame, pulse VALID with DATA_T = 0xFF and change DATA_T mid-frame. The line still carries 0x3C, and no second frame starts.
- Reset mid-frame: assert RST_N low during bit 3 of 0x55. TX goes to 1 with no clock edge needed, and BUSY = 0. After release, sending 0x81 yields a clean frame.
- Loopback: drive the receiver from TX with a matching divider. Send 0x00, 0x7E, 0xFF; the receiver output equals each byte in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and divider sizing.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 5208;
    localparam int BAUD_CNT_W       = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..BAUD_DIV-1 while enabled and pulses tick
// on the last count; clr restarts the period so a new frame aligns to it.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(BAUD_DIV - 1);

    logic [BAUD_CNT_W-1:0] cnt_reg;

    assign tick = en && (cnt_reg == LAST_CNT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte input and a registered TX line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DATA_T,
    input  logic       VALID,
    output logic       READY,
    output logic       TX,
    output logic       BUSY
);

    uart_state_t          state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           idx_reg, idx_next;
    logic                 tx_reg, tx_next;
    logic                 accept;
    logic                 tick;

    assign READY  = (state_reg == IDLE);
    assign BUSY   = (state_reg != IDLE);
    assign TX     = tx_reg;
    assign accept = VALID && READY;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (accept),
        .en    (BUSY),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            idx_reg   <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            tx_reg    <= tx_next;
        end
    end

    // TX is computed one step ahead so the line changes on the same edge as the state.
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        tx_next    = tx_reg;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (accept) begin
                    shift_next = DATA_T;
                    idx_next   = '0;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_reg == 3'(DATA_BITS - 1)) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next = shift_reg >> 1;
                        idx_next   = idx_reg + 3'd1;
                        tx_next    = shift_reg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

endmodule
